// File: rtl/picmicro_pkg.sv
// Shared definitions for the instruction fetch path: NOP encoding, Q-phase
// numbering and the fetch sequencer state type.
package picmicro_pkg;

    localparam int NOP_WIDTH = 14;
    localparam logic [NOP_WIDTH-1:0] NOP_OPCODE = '0;

    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET_FILL = 2'd0,
        ST_RUN        = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_SLEEP      = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/q_phase_counter.sv
// Four-phase instruction-cycle counter (Q1..Q4); freezes while hold is high.
module q_phase_counter
    import picmicro_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    output logic [1:0] q_phase
);

    logic [1:0] phase_q;
    logic [1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (!hold) begin
            case (phase_q)
                Q1:      phase_d = Q2;
                Q2:      phase_d = Q3;
                Q3:      phase_d = Q4;
                default: phase_d = Q1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= Q1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign q_phase = phase_q;

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Q-cycle fetch sequencer: paces program-memory fetches, squashes the prefetched
// word after a flush and optionally parks the core in SLEEP (FETCH_SLEEP_EN).
module instruction_fetch_sequencer
    import picmicro_pkg::*;
#(
    parameter int INSTR_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   flush_req,
    input  logic                   sleep_req,
    input  logic                   wake,
    output logic [1:0]             q_phase,
    output logic                   instr_rd_en,
    output logic                   incr_pc_en,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic                   sleeping
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         fetch_strobe;

    q_phase_counter u_q_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .hold    (state_q == ST_SLEEP),
        .q_phase (q_phase)
    );

    // Requests are only honoured on the Q4 edge; SLEEP exits on any edge with wake.
    always_comb begin
        state_d      = state_q;
        fetch_strobe = 1'b0;
        case (state_q)
            ST_SLEEP: begin
`ifdef FETCH_SLEEP_EN
                if (wake) begin
                    state_d = ST_RUN;
                end
`endif
            end
            default: begin
                if (q_phase == Q4) begin
                    fetch_strobe = !flush_req;
                    if (flush_req) begin
                        state_d = ST_FLUSH;
`ifdef FETCH_SLEEP_EN
                    end else if (sleep_req) begin
                        state_d = ST_SLEEP;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RESET_FILL;
        end else begin
            state_q <= state_d;
        end
    end

`ifndef FETCH_SLEEP_EN
    logic unused_sleep_inputs;
    assign unused_sleep_inputs = sleep_req ^ wake;
`endif

    assign instr_rd_en = fetch_strobe;
    assign incr_pc_en  = fetch_strobe;
    assign instr_valid = (state_q == ST_RUN);
    assign sleeping    = (state_q == ST_SLEEP);
    assign instr_out   = instr_valid ? instr_in : INSTR_WIDTH'(NOP_OPCODE);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer: directed scenarios plus
// randomized traffic, all compared against an instruction-cycle level model.
module tb_instruction_fetch_sequencer;

    localparam int W = 14;
`ifdef FETCH_SLEEP_EN
    localparam bit SLEEP_EN = 1'b1;
`else
    localparam bit SLEEP_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] instr_in;
    logic         flush_req;
    logic         sleep_req;
    logic         wake;
    logic [1:0]   q_phase;
    logic         instr_rd_en;
    logic         incr_pc_en;
    logic [W-1:0] instr_out;
    logic         instr_valid;
    logic         sleeping;

    int checkCount = 0;
    int errorCount = 0;

    // Model: clock position inside the instruction cycle, whether the current
    // cycle executes a real instruction, and whether the core is asleep.
    int mPhase;
    bit mValid;
    bit mAsleep;

    instruction_fetch_sequencer #(.INSTR_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .flush_req   (flush_req),
        .sleep_req   (sleep_req),
        .wake        (wake),
        .q_phase     (q_phase),
        .instr_rd_en (instr_rd_en),
        .incr_pc_en  (incr_pc_en),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .sleeping    (sleeping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase  = 0;
        mValid  = 1'b0;
        mAsleep = 1'b0;
    endtask

    // One rising edge of the model: a sleeping core only listens to wake; an
    // awake core decides the next instruction cycle's fate at the end of Q4.
    task automatic modelStep(input bit f, input bit s, input bit w);
        if (mAsleep) begin
            if (SLEEP_EN && w) begin
                mAsleep = 1'b0;
                mValid  = 1'b1;
            end
        end else begin
            if (mPhase == 3) begin
                if (f) begin
                    mValid = 1'b0;
                end else if (SLEEP_EN && s) begin
                    mAsleep = 1'b1;
                    mValid  = 1'b0;
                end else begin
                    mValid = 1'b1;
                end
            end
            mPhase = (mPhase + 1) % 4;
        end
    endtask

    task automatic checkAll();
        logic         expStrobe;
        logic [W-1:0] expOut;
        expStrobe = !mAsleep && (mPhase == 3) && !flush_req && rst;
        expOut    = mValid ? instr_in : '0;
        checkOutput("q_phase", 32'(q_phase), 32'(mPhase));
        checkOutput("instr_valid", 32'(instr_valid), 32'(mValid));
        checkOutput("instr_out", 32'(instr_out), 32'(expOut));
        checkOutput("instr_rd_en", 32'(instr_rd_en), 32'(expStrobe));
        checkOutput("incr_pc_en", 32'(incr_pc_en), 32'(expStrobe));
        checkOutput("sleeping", 32'(sleeping), 32'(mAsleep));
    endtask

    // Drive one clock: inputs change at the falling edge, outputs are checked
    // just after, and the model advances on the following rising edge.
    task automatic applyStimulus(input logic r, input logic f, input logic s,
                                 input logic w, input logic [W-1:0] instr);
        @(negedge clk);
        rst       = r;
        flush_req = f;
        sleep_req = s;
        wake      = w;
        instr_in  = instr;
        #1;
        if (!r) modelReset();
        checkAll();
        @(posedge clk);
        if (r) modelStep(f, s, w);
    endtask

    task automatic idle(input int n, input logic [W-1:0] instr);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, instr);
    endtask

    task automatic runUntilPhase(input int p, input logic [W-1:0] instr);
        int budget;
        budget = 0;
        while (mPhase != p && budget < 8) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, instr);
            budget++;
        end
        if (mPhase != p) begin
            errorCount++;
            $display("[TB] FAIL phaseTimeout: got %0d, expected %0d", mPhase, p);
        end
    endtask

    initial begin
        rst = 1'b0; flush_req = 1'b0; sleep_req = 1'b0; wake = 1'b0; instr_in = '0;
        modelReset();

        // Reset, then release with a constant word on the bus.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 14'h3005);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 14'h3005);
        idle(20, 14'h3005);

        // Flush at a Q4, then let the pipeline refill.
        runUntilPhase(3, 14'h3005);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'h3005);
        idle(8, 14'h1A2B);

        // Sleep with wake coincident on the entry edge, then a long nap.
        runUntilPhase(3, 14'h0123);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 14'h0123);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'h0456);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 14'h0456);
        idle(6, 14'h0456);

        // Flush and sleep together: flush must win.
        runUntilPhase(3, 14'h2222);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 14'h2222);
        idle(5, 14'h2222);

        // Reset landing at Q2 of a FLUSH cycle.
        runUntilPhase(3, 14'h3333);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'h3333);
        runUntilPhase(1, 14'h3333);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 14'h3333);
        idle(9, 14'h3333);

        // Reset while asleep.
        runUntilPhase(3, 14'h0F0F);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 14'h0F0F);
        idle(3, 14'h0F0F);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 14'h0F0F);
        idle(9, 14'h0F0F);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(logic'($urandom_range(0, 99) != 0),
                          logic'($urandom_range(0, 5) == 0),
                          logic'($urandom_range(0, 7) == 0),
                          logic'($urandom_range(0, 9) == 0),
                          W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
